// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder_arbiter block: default sizes, the
// requester-ID width helper and the operand-pair record.
package adder_arb_pkg;

    localparam int ADDER_ARB_W    = 8;
    localparam int ADDER_ARB_NREQ = 4;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int idw_f(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [ADDER_ARB_W-1:0] a;
        logic [ADDER_ARB_W-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin grant selection: searches req_i starting at ptr_i and
// wrapping mod NREQ; the first requester found wins. grant_o is one-hot
// only when en_i is high, winner_o/found_o report the search regardless.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NREQ = ADDER_ARB_NREQ,
    localparam int IDW  = idw_f(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  winner_o,
    output logic            found_o
);

    // cand_idx[k] is the requester examined k-th in the search order.
    logic [IDW-1:0]  cand_idx [NREQ];
    logic [NREQ-1:0] cand_req;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = (int'(ptr_i) + gi >= NREQ) ?
                                  IDW'(int'(ptr_i) + gi - NREQ) :
                                  IDW'(int'(ptr_i) + gi);
            assign cand_req[gi] = req_i[cand_idx[gi]];
        end
    endgenerate

    // Priority pick over the rotated order; scanning downwards lets the
    // earliest candidate overwrite later ones.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                found_o  = 1'b1;
                winner_o = cand_idx[k];
            end
        end
    end

    assign grant_o = (found_o && en_i) ?
                     ({{(NREQ-1){1'b0}}, 1'b1} << winner_o) : '0;

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one W-bit adder among NREQ valid/ready requesters
// with round-robin arbitration and a registered, ID-tagged response.
// Optional feature macro: ADDER_ARB_CARRY_EN adds the rsp_carry port and
// widens the adder by one bit so the carry is registered with the sum.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NREQ = ADDER_ARB_NREQ,
    parameter  int W    = ADDER_ARB_W,
    localparam int IDW  = idw_f(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
`ifdef ADDER_ARB_CARRY_EN
    output logic              rsp_carry,
`endif
    output logic [IDW-1:0]    rsp_id
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_sum_q,   rsp_sum_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic [IDW-1:0]  ptr_q,       ptr_d;
`ifdef ADDER_ARB_CARRY_EN
    logic            rsp_carry_q, rsp_carry_d;
`endif

    logic            can_accept;
    logic            found;
    logic            xfer;
    logic [IDW-1:0]  winner;
    logic [W-1:0]    a_mux;
    logic [W-1:0]    b_mux;

    // The result register can take a new sum if it is empty or draining.
    assign can_accept = !rsp_valid_q || rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .en_i     (can_accept),
        .grant_o  (req_ready),
        .winner_o (winner),
        .found_o  (found)
    );

    assign xfer  = found && can_accept;

    // Operands of the winning requester feed the one shared adder.
    assign a_mux = req_a[int'(winner)*W +: W];
    assign b_mux = req_b[int'(winner)*W +: W];

`ifdef ADDER_ARB_CARRY_EN
    logic [W:0] add_res;
    assign add_res = {1'b0, a_mux} + {1'b0, b_mux};
`else
    logic [W-1:0] add_res;
    assign add_res = a_mux + b_mux;
`endif

    // Next-state: load on transfer, otherwise drain or hold the response.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
`ifdef ADDER_ARB_CARRY_EN
        rsp_carry_d = rsp_carry_q;
`endif
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_res[W-1:0];
            rsp_id_d    = winner;
            ptr_d       = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
`ifdef ADDER_ARB_CARRY_EN
            rsp_carry_d = add_res[W];
`endif
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register and round-robin pointer; reset clears them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
`ifdef ADDER_ARB_CARRY_EN
            rsp_carry_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
`ifdef ADDER_ARB_CARRY_EN
            rsp_carry_q <= rsp_carry_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
`ifdef ADDER_ARB_CARRY_EN
    assign rsp_carry = rsp_carry_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a requester/response reference model.
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic [IDW-1:0]    rsp_id;
`ifdef ADDER_ARB_CARRY_EN
    logic              rsp_carry;
`endif

    always #5 clk = ~clk;

    adder_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
`ifdef ADDER_ARB_CARRY_EN
        .rsp_carry (rsp_carry),
`endif
        .rsp_id    (rsp_id)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Requester side: what each requester currently offers.
    operand_pair_t offer   [NREQ];
    bit            offer_v [NREQ];

    // Reference model of the response register and the fairness pointer.
    bit m_valid;
    int m_sum, m_id, m_carry, m_ptr;
    int last_grant;
    int n_xfer;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic offer_set(input int i, input int a, input int b);
        offer[i].a = a[7:0];
        offer[i].b = b[7:0];
        offer_v[i] = 1'b1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = 0;
        m_id    = 0;
        m_carry = 0;
        m_ptr   = 0;
    endtask

    // One clock cycle, entered and left at a falling edge. Drives the
    // offers, checks outputs against the model, then advances the model.
    task automatic run_cycle();
        int w;
        int s;
        bit can;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = offer_v[i];
            req_a[i*W +: W]    = offer[i].a;
            req_b[i*W +: W]    = offer[i].b;
        end
        #1;
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("rsp_sum", {24'd0, rsp_sum}, m_sum);
            chk("rsp_id", {30'd0, rsp_id}, m_id);
`ifdef ADDER_ARB_CARRY_EN
            chk("rsp_carry", {31'd0, rsp_carry}, m_carry);
`endif
        end
        can = !m_valid || rsp_ready;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && offer_v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        chk("req_ready", {28'd0, req_ready}, (w >= 0 && can) ? (32'd1 << w) : 32'd0);
        @(posedge clk);
        if (w >= 0 && can) begin
            s          = int'(offer[w].a) + int'(offer[w].b);
            m_valid    = 1'b1;
            m_sum      = s % 256;
            m_carry    = s / 256;
            m_id       = w;
            m_ptr      = (w + 1) % NREQ;
            offer_v[w] = 1'b0;
            last_grant = w;
            n_xfer++;
            $display("xfer %0d: id=%0d a=0x%02h b=0x%02h exp_sum=0x%02h",
                     n_xfer, w, offer[w].a, offer[w].b, m_sum);
        end else begin
            last_grant = -1;
            if (rsp_ready) m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g;
        int wait_x;
        bit fair_done;

        rst        = 1'b1;
        rsp_ready  = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        last_grant = -1;
        n_xfer     = 0;
        for (int i = 0; i < NREQ; i++) begin
            offer_v[i] = 1'b0;
            offer[i]   = '0;
        end
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_sum", {24'd0, rsp_sum}, 32'd0);
        chk("rst_id", {30'd0, rsp_id}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single request from requester 2
        offer_set(2, 'h35, 'h4A);
        run_cycle();
        chk("single_grant", last_grant, 2);
        chk("single_sum", {24'd0, rsp_sum}, 32'h7F);
        chk("single_id", {30'd0, rsp_id}, 2);
        run_cycle();

        // Overflow wraps mod 2^W
        offer_set(0, 'hFF, 'h01);
        run_cycle();
        chk("ovf_sum", {24'd0, rsp_sum}, 32'h00);
`ifdef ADDER_ARB_CARRY_EN
        chk("ovf_carry", {31'd0, rsp_carry}, 32'd1);
`endif
        run_cycle();

        // All requesters continuously valid: strict rotation, one per cycle
        exp_g = m_ptr;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!offer_v[i]) offer_set(i, $urandom_range(0, 255), $urandom_range(0, 255));
            run_cycle();
            chk("rr_order", last_grant, exp_g);
            exp_g = (exp_g + 1) % NREQ;
        end

        // Back-pressure: result held, nothing accepted for 3 cycles
        for (int i = 0; i < NREQ; i++)
            if (!offer_v[i]) offer_set(i, $urandom_range(0, 255), $urandom_range(0, 255));
        rsp_ready = 1'b0;
        exp_g = m_sum;
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            chk("bp_no_grant", last_grant, -1);
            chk("bp_hold_sum", {24'd0, rsp_sum}, exp_g);
        end
        rsp_ready = 1'b1;
        run_cycle();
        chk("bp_drain_grant", {31'd0, last_grant >= 0}, 32'd1);

        // Empty all pending offers
        for (int c = 0; c < NREQ + 1; c++) run_cycle();

        // Fairness: requester 0 always busy, requester 3 joins at cycle 5
        fair_done = 1'b0;
        wait_x    = 0;
        for (int c = 0; c < 30 && !fair_done; c++) begin
            if (!offer_v[0]) offer_set(0, $urandom_range(0, 255), $urandom_range(0, 255));
            if (!offer_v[1] && $urandom_range(0, 1) == 1)
                offer_set(1, $urandom_range(0, 255), $urandom_range(0, 255));
            if (c == 5) offer_set(3, $urandom_range(0, 255), $urandom_range(0, 255));
            run_cycle();
            if (c >= 5 && last_grant >= 0) wait_x++;
            if (c >= 5 && last_grant == 3) begin
                fair_done = 1'b1;
                chk("fair_wait", {31'd0, wait_x <= NREQ}, 32'd1);
            end
        end
        chk("fair_granted", {31'd0, fair_done}, 32'd1);

        // Randomized traffic with random back-pressure
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++)
                if (!offer_v[i] && $urandom_range(0, 1) == 1)
                    offer_set(i, $urandom_range(0, 255), $urandom_range(0, 255));
            run_cycle();
        end

        // Reset mid-stream: outputs drop without a clock edge
        rsp_ready = 1'b1;
        for (int c = 0; c < NREQ + 1; c++) run_cycle();
        offer_set(2, 'h10, 'h20);
        run_cycle();
        chk("mid_valid_before", {31'd0, rsp_valid}, 32'd1);
        offer_set(1, 'h11, 'h22);
        offer_set(3, 'h33, 'h44);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_sum", {24'd0, rsp_sum}, 32'd0);
        chk("async_id", {30'd0, rsp_id}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_cycle();
        chk("post_rst_grant", last_grant, 1);
        run_cycle();
        chk("post_rst_next", last_grant, 3);
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
